// File: rtl/reg_bus_master.sv
// reg_bus_master: turns single command/response transactions into
// register-bus accesses (cs/we/address/write_data out, read_data/error in).
// Each access pulses cs for one cycle, then waits RD_LATENCY cycles before
// it samples the slave. It then holds the response until it is taken.
// Optional feature macro: REG_BUS_MASTER_RETRY_EN. When it is defined, an
// access that errors is reissued up to MAX_RETRIES extra times.
module reg_bus_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8,
    parameter int RD_LATENCY    = 1,
    parameter int MAX_RETRIES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_error,
    output logic                     cs,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    read_data,
    input  logic                     error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LatLoad = 4'(RD_LATENCY);

    // Stop elaboration of configurations that the counters cannot represent
    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_badLatency
        $error("reg_bus_master: RD_LATENCY must be within 1..15");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > 7) begin : g_badRetries
        $error("reg_bus_master: MAX_RETRIES must be within 1..7");
    end

    state_t                   r_state;
    logic                     r_cmdReady;
    logic                     r_cs;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0]    r_writeData;
    logic                     r_rspValid;
    logic [DATA_WIDTH-1:0]    r_rspRdata;
    logic                     r_rspError;
    logic [3:0]               r_latCount;
`ifdef REG_BUS_MASTER_RETRY_EN
    logic [2:0]               r_retryCount;
`endif

    // Transaction sequencer: every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cmdReady   <= 1'b1;
            r_cs         <= 1'b0;
            r_we         <= 1'b0;
            r_address    <= '0;
            r_writeData  <= '0;
            r_rspValid   <= 1'b0;
            r_rspRdata   <= '0;
            r_rspError   <= 1'b0;
            r_latCount   <= '0;
`ifdef REG_BUS_MASTER_RETRY_EN
            r_retryCount <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_we        <= cmd_we;
                        r_address   <= cmd_addr;
                        r_writeData <= cmd_wdata;
                        r_cs        <= 1'b1;
                        r_cmdReady  <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cs       <= 1'b0;
                    r_latCount <= LatLoad;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    r_latCount <= r_latCount - 4'd1;
                    if (r_latCount == 4'd1) begin
`ifdef REG_BUS_MASTER_RETRY_EN
                        if (error && (r_retryCount < 3'(MAX_RETRIES))) begin
                            r_retryCount <= r_retryCount + 3'd1;
                            r_cs         <= 1'b1;
                            r_state      <= ISSUE;
                        end else begin
                            r_rspValid <= 1'b1;
                            r_rspRdata <= r_we ? '0 : read_data;
                            r_rspError <= error;
                            r_state    <= RESP;
                        end
`else
                        r_rspValid <= 1'b1;
                        r_rspRdata <= r_we ? '0 : read_data;
                        r_rspError <= error;
                        r_state    <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid   <= 1'b0;
                        r_cmdReady   <= 1'b1;
                        r_state      <= IDLE;
`ifdef REG_BUS_MASTER_RETRY_EN
                        r_retryCount <= '0;
`endif
                    end
                end
                default: begin
                    r_cs       <= 1'b0;
                    r_rspValid <= 1'b0;
                    r_cmdReady <= 1'b1;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmdReady;
    assign cs         = r_cs;
    assign we         = r_we;
    assign address    = r_address;
    assign write_data = r_writeData;
    assign rsp_valid  = r_rspValid;
    assign rsp_rdata  = r_rspRdata;
    assign rsp_error  = r_rspError;

endmodule
